tri_wave_analyzer: RTL and testbench
====================================

Name: tri_wave_analyzer

Overview:
Receive-side counterpart of the triangle generator. Consumes a qualified stream of signed 32-bit triangle samples and finds peaks and troughs with hysteresis. On each peak it reports the period in samples, the peak and trough values, and the amplitude, and it asserts a lock flag once the period is stable. Sits downstream of the waveform source, or of the DSP chain fed by it, as the measurement/self-check block.

Parameters:
DATA_W, 32, sample width, signed two's complement
PERIOD_W, 24, width of period/age counters
HYST, 16, hysteresis in LSBs for slope-reversal detection (unsigned, >0)
LOCK_CNT, 4, consecutive matching periods required to assert lock
TOL, 2, max |period - previous period| counted as matching
MAX_PERIOD, 2**24-1, sample age at which measurement times out

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_valid  in  1  sample qualifier; one sample per asserted cycle
i_sample  in  DATA_W  signed input sample
o_valid  out  1  one-cycle pulse: new measurement on outputs
o_period  out  PERIOD_W  samples between last two peak positions
o_peak  out  DATA_W  signed value of last peak
o_trough  out  DATA_W  signed value of last trough
o_ampl  out  DATA_W+1  o_peak - o_trough, signed, no overflow
o_locked  out  1  period stable
o_timeout  out  1  one-cycle pulse on measurement timeout

Behaviour:
- Reset (sync, i_rst=1 at posedge): all outputs 0; FSM=IDLE; counters, extremes and lock state cleared; first-peak flag cleared. Applies mid-operation; the next valid sample is treated as the first sample.
- Cycles with i_valid=0 change nothing. All counters count valid samples, not clocks.
- ts: PERIOD_W-bit sample timestamp. Increments on every valid sample and wraps modulo 2^PERIOD_W.
- FSM states: IDLE, RISING, FALLING.
  - IDLE: first valid sample loads run_max=run_min=sample. Later samples update run_max/run_min. If sample >= run_min+HYST, go to RISING with run_max=sample, ts_max=ts. If sample <= run_max-HYST, go to FALLING with run_min=sample. Rise has priority if both hold.
  - RISING: if sample > run_max (strict, so the first sample of a flat top wins), set run_max=sample and ts_max=ts. If sample <= run_max-HYST, it is a peak event: go to FALLING and set run_min=sample.
  - FALLING: if sample < run_min, set run_min=sample. If sample >= run_min+HYST, it is a trough event: o_trough<=run_min, go to RISING, run_max=sample, ts_max=ts.
- Comparisons use DATA_W+1-bit signed arithmetic, so ±HYST never overflows.
- Peak event, registered at the posedge after the triggering sample (latency 1):
  - First peak after reset/timeout: store prev_ts=ts_max and o_peak. No o_valid.
  - Later peaks: o_period=ts_max-prev_ts (mod 2^PERIOD_W), o_peak=run_max, o_ampl=run_max-o_trough (using the trough register value), o_valid=1 for one cycle, prev_ts=ts_max.
- Lock: match_cnt increments when |period-last_period| <= TOL and saturates at LOCK_CNT. Otherwise it resets to 0. o_locked = (match_cnt==LOCK_CNT). It updates on the same cycle as o_valid.
- Timeout: age counts valid samples since the last peak event, or since leaving IDLE. When age reaches MAX_PERIOD: o_timeout pulses one cycle, FSM goes to IDLE, o_locked=0, match_cnt=0, first-peak flag cleared. o_period/o_peak/o_trough hold their values. A timeout and a peak event on the same sample: the peak wins and age resets.
- A constant input never leaves IDLE and produces no o_valid. It reaches timeout only if it occurs after leaving IDLE.

Decomposition:
- Package tri_pkg: state enum (IDLE, RISING, FALLING); default DATA_W/PERIOD_W localparams; a shared sample typedef, so the generator and analyzer agree on width.
- Sub-module tri_extreme_tracker: FSM, run_max/run_min, ts_max, and peak/trough event strobes.
- Top level: period subtraction, lock counter, timeout, output registers.

Test Plan:
- Reset, then ramp -100→100→-100 in steps of 10 (period 40), HYST=16, i_valid=1 continuously, 3 cycles -> first peak gives no o_valid. Each later peak gives o_period=40, o_peak=100, o_trough=-100, o_ampl=200, with o_valid one clock after the sample 80 following the peak.
- Same wave for 6 periods with LOCK_CNT=4 -> o_locked rises on the 4th matching o_valid. Then switch to a period of 60 (steps of ~6.67, rounded) -> o_locked=0 on the first 60-period o_valid.
- Wave with i_valid toggling 1/0 every cycle -> o_period still 40 (valid-sample count), o_valid spacing 80 clocks.
- Add ±7 ripple (< HYST) on the ramp -> no extra peak/trough events; o_period=40 ±1.
- Hold the input at 50 after the first peak with MAX_PERIOD=100 -> o_timeout pulses 100 samples after that peak, o_locked=0; a restarted wave needs two peaks before o_valid.
- Assert i_rst for 1 cycle mid-ramp -> all outputs 0 next cycle; resumed wave re-acquires with no stale period.

Source files
------------

// File: rtl/tri_pkg.sv
// Shared definitions for the triangle-wave generator/analyzer pair.
// FSM state encodings and default widths live here so both ends agree.
package tri_pkg;

    localparam int unsigned DefDataW   = 32;
    localparam int unsigned DefPeriodW = 24;

    typedef logic [1:0] state_t;

    localparam state_t StIdle    = 2'd0;
    localparam state_t StRising  = 2'd1;
    localparam state_t StFalling = 2'd2;

    typedef logic signed [DefDataW-1:0] sample_t;

endpackage

// File: rtl/tri_extreme_tracker.sv
// Slope-tracking FSM with hysteresis: follows the running extreme of the current
// slope and strobes a peak/trough event on the sample that reverses it.
module tri_extreme_tracker
    import tri_pkg::*;
#(
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned PERIOD_W = DefPeriodW,
    parameter int unsigned HYST     = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       valid_i,
    input  logic                       clear_i,
    input  logic signed [DATA_W-1:0]   sample_i,
    input  logic        [PERIOD_W-1:0] ts_i,
    output state_t                     state_o,
    output logic                       peak_o,
    output logic                       trough_o,
    output logic                       leave_idle_o,
    output logic signed [DATA_W-1:0]   run_max_o,
    output logic signed [DATA_W-1:0]   run_min_o,
    output logic        [PERIOD_W-1:0] ts_max_o
);

    localparam logic signed [DATA_W:0] HystExt = (DATA_W + 1)'(HYST);

    state_t                     state_q, state_d;
    logic signed [DATA_W-1:0]   run_max_q, run_max_d;
    logic signed [DATA_W-1:0]   run_min_q, run_min_d;
    logic        [PERIOD_W-1:0] ts_max_q, ts_max_d;
    logic                       init_q, init_d;

    // One extra bit so the thresholds never wrap at the rails.
    logic signed [DATA_W:0] sample_ext;
    logic signed [DATA_W:0] rise_thr;
    logic signed [DATA_W:0] fall_thr;
    logic                   rise_hit;
    logic                   fall_hit;

    assign sample_ext = $signed({sample_i[DATA_W-1], sample_i});
    assign rise_thr   = $signed({run_min_q[DATA_W-1], run_min_q}) + HystExt;
    assign fall_thr   = $signed({run_max_q[DATA_W-1], run_max_q}) - HystExt;
    assign rise_hit   = sample_ext >= rise_thr;
    assign fall_hit   = sample_ext <= fall_thr;

    always_comb begin
        state_d      = state_q;
        run_max_d    = run_max_q;
        run_min_d    = run_min_q;
        ts_max_d     = ts_max_q;
        init_d       = init_q;
        peak_o       = 1'b0;
        trough_o     = 1'b0;
        leave_idle_o = 1'b0;
        if (valid_i) begin
            case (state_q)
                StIdle: begin
                    if (!init_q) begin
                        run_max_d = sample_i;
                        run_min_d = sample_i;
                        init_d    = 1'b1;
                    end else if (rise_hit) begin
                        state_d      = StRising;
                        run_max_d    = sample_i;
                        ts_max_d     = ts_i;
                        leave_idle_o = 1'b1;
                    end else if (fall_hit) begin
                        state_d      = StFalling;
                        run_min_d    = sample_i;
                        leave_idle_o = 1'b1;
                    end else begin
                        if (sample_i > run_max_q) run_max_d = sample_i;
                        if (sample_i < run_min_q) run_min_d = sample_i;
                    end
                end
                StRising: begin
                    // Strict compare keeps the first sample of a flat top.
                    if (sample_i > run_max_q) begin
                        run_max_d = sample_i;
                        ts_max_d  = ts_i;
                    end else if (fall_hit) begin
                        peak_o    = 1'b1;
                        state_d   = StFalling;
                        run_min_d = sample_i;
                    end
                end
                StFalling: begin
                    if (sample_i < run_min_q) begin
                        run_min_d = sample_i;
                    end else if (rise_hit) begin
                        trough_o  = 1'b1;
                        state_d   = StRising;
                        run_max_d = sample_i;
                        ts_max_d  = ts_i;
                    end
                end
                default: state_d = StIdle;
            endcase
            if (clear_i) begin
                state_d = StIdle;
                init_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            run_max_q <= '0;
            run_min_q <= '0;
            ts_max_q  <= '0;
            init_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_max_q <= run_max_d;
            run_min_q <= run_min_d;
            ts_max_q  <= ts_max_d;
            init_q    <= init_d;
        end
    end

    assign state_o   = state_q;
    assign run_max_o = run_max_q;
    assign run_min_o = run_min_q;
    assign ts_max_o  = ts_max_q;

endmodule

// File: rtl/tri_wave_analyzer.sv
// Triangle-wave analyzer: measures period, peak, trough and amplitude of a
// qualified sample stream, flags period lock and reports measurement timeouts.
module tri_wave_analyzer
    import tri_pkg::*;
#(
    parameter int unsigned DATA_W     = DefDataW,
    parameter int unsigned PERIOD_W   = DefPeriodW,
    parameter int unsigned HYST       = 16,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned TOL        = 2,
    parameter int unsigned MAX_PERIOD = 2**24 - 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    input  logic signed [DATA_W-1:0]   i_sample,
    output logic                       o_valid,
    output logic        [PERIOD_W-1:0] o_period,
    output logic signed [DATA_W-1:0]   o_peak,
    output logic signed [DATA_W-1:0]   o_trough,
    output logic signed [DATA_W:0]     o_ampl,
    output logic                       o_locked,
    output logic                       o_timeout
);

    localparam int unsigned            MatchW  = $clog2(LOCK_CNT + 1);
    localparam logic [MatchW-1:0]      LockMax = MatchW'(LOCK_CNT);
    localparam logic [PERIOD_W-1:0]    AgeLast = PERIOD_W'(MAX_PERIOD - 1);
    localparam logic [PERIOD_W-1:0]    TolP    = PERIOD_W'(TOL);

    state_t                     trk_state;
    logic                       trk_peak;
    logic                       trk_trough;
    logic                       trk_leave_idle;
    logic signed [DATA_W-1:0]   trk_run_max;
    logic signed [DATA_W-1:0]   trk_run_min;
    logic        [PERIOD_W-1:0] trk_ts_max;
    logic                       timeout_hit;

    logic        [PERIOD_W-1:0] ts_q, ts_d;
    logic        [PERIOD_W-1:0] age_q, age_d;
    logic        [PERIOD_W-1:0] prev_ts_q, prev_ts_d;
    logic        [PERIOD_W-1:0] last_period_q, last_period_d;
    logic        [MatchW-1:0]   match_q, match_d;
    logic                       have_peak_q, have_peak_d;
    logic                       valid_q, valid_d;
    logic        [PERIOD_W-1:0] period_q, period_d;
    logic signed [DATA_W-1:0]   peak_q, peak_d;
    logic signed [DATA_W-1:0]   trough_q, trough_d;
    logic signed [DATA_W:0]     ampl_q, ampl_d;
    logic                       locked_q, locked_d;
    logic                       timeout_q, timeout_d;

    logic        [PERIOD_W-1:0] period_new;
    logic        [PERIOD_W-1:0] period_diff;
    logic                       period_match;
    logic signed [DATA_W:0]     ampl_new;

    tri_extreme_tracker #(
        .DATA_W   (DATA_W),
        .PERIOD_W (PERIOD_W),
        .HYST     (HYST)
    ) u_tracker (
        .clk_i        (i_clk),
        .rst_i        (i_rst),
        .valid_i      (i_valid),
        .clear_i      (timeout_hit),
        .sample_i     (i_sample),
        .ts_i         (ts_q),
        .state_o      (trk_state),
        .peak_o       (trk_peak),
        .trough_o     (trk_trough),
        .leave_idle_o (trk_leave_idle),
        .run_max_o    (trk_run_max),
        .run_min_o    (trk_run_min),
        .ts_max_o     (trk_ts_max)
    );

    // A peak on the same sample pre-empts the timeout.
    assign timeout_hit = i_valid && (trk_state != StIdle) && !trk_peak && (age_q == AgeLast);

    assign period_new   = trk_ts_max - prev_ts_q;
    assign period_diff  = (period_new >= last_period_q) ? period_new - last_period_q
                                                        : last_period_q - period_new;
    assign period_match = period_diff <= TolP;
    assign ampl_new     = $signed({trk_run_max[DATA_W-1], trk_run_max})
                        - $signed({trough_q[DATA_W-1], trough_q});

    always_comb begin
        ts_d          = ts_q;
        age_d         = age_q;
        prev_ts_d     = prev_ts_q;
        last_period_d = last_period_q;
        match_d       = match_q;
        have_peak_d   = have_peak_q;
        valid_d       = 1'b0;
        period_d      = period_q;
        peak_d        = peak_q;
        trough_d      = trough_q;
        ampl_d        = ampl_q;
        locked_d      = locked_q;
        timeout_d     = 1'b0;
        if (i_valid) begin
            ts_d = ts_q + 1'b1;
            if (trk_leave_idle || trk_peak) begin
                age_d = '0;
            end else if (trk_state != StIdle) begin
                age_d = age_q + 1'b1;
            end
            if (trk_trough && !timeout_hit) begin
                trough_d = trk_run_min;
            end
            if (trk_peak) begin
                prev_ts_d = trk_ts_max;
                peak_d    = trk_run_max;
                if (have_peak_q) begin
                    valid_d       = 1'b1;
                    period_d      = period_new;
                    ampl_d        = ampl_new;
                    last_period_d = period_new;
                    if (!period_match) begin
                        match_d = '0;
                    end else if (match_q != LockMax) begin
                        match_d = match_q + 1'b1;
                    end
                    locked_d = (match_d == LockMax);
                end
                have_peak_d = 1'b1;
            end
            if (timeout_hit) begin
                age_d         = '0;
                timeout_d     = 1'b1;
                locked_d      = 1'b0;
                match_d       = '0;
                last_period_d = '0;
                have_peak_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ts_q          <= '0;
            age_q         <= '0;
            prev_ts_q     <= '0;
            last_period_q <= '0;
            match_q       <= '0;
            have_peak_q   <= 1'b0;
            valid_q       <= 1'b0;
            period_q      <= '0;
            peak_q        <= '0;
            trough_q      <= '0;
            ampl_q        <= '0;
            locked_q      <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            ts_q          <= ts_d;
            age_q         <= age_d;
            prev_ts_q     <= prev_ts_d;
            last_period_q <= last_period_d;
            match_q       <= match_d;
            have_peak_q   <= have_peak_d;
            valid_q       <= valid_d;
            period_q      <= period_d;
            peak_q        <= peak_d;
            trough_q      <= trough_d;
            ampl_q        <= ampl_d;
            locked_q      <= locked_d;
            timeout_q     <= timeout_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_period  = period_q;
    assign o_peak    = peak_q;
    assign o_trough  = trough_q;
    assign o_ampl    = ampl_q;
    assign o_locked  = locked_q;
    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_tri_wave_analyzer.sv
// Directed bench for tri_wave_analyzer: triangle ramps, lock, gaps, ripple,
// timeout and mid-stream reset, with hand-derived expected values.
module tb_tri_wave_analyzer;

    logic               clk = 1'b0;
    logic               i_rst;
    logic               i_valid;
    logic signed [31:0] i_sample;
    logic               o_valid;
    logic        [23:0] o_period;
    logic signed [31:0] o_peak;
    logic signed [31:0] o_trough;
    logic signed [32:0] o_ampl;
    logic               o_locked;
    logic               o_timeout;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tri_wave_analyzer #(
        .DATA_W     (32),
        .PERIOD_W   (24),
        .HYST       (16),
        .LOCK_CNT   (4),
        .TOL        (2),
        .MAX_PERIOD (100)
    ) dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .i_valid   (i_valid),
        .i_sample  (i_sample),
        .o_valid   (o_valid),
        .o_period  (o_period),
        .o_peak    (o_peak),
        .o_trough  (o_trough),
        .o_ampl    (o_ampl),
        .o_locked  (o_locked),
        .o_timeout (o_timeout)
    );

    // Triangle from -100 to +100 over 'half' samples, rounded to nearest.
    function automatic int tri_val(input int k, input int half);
        int p;
        int v;
        p = k % (2 * half);
        v = (p <= half) ? p : 2 * half - p;
        return -100 + (200 * v + half / 2) / half;
    endfunction

    task automatic send(input int s, input logic v);
        i_valid  = v;
        i_sample = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst    = 1'b1;
        i_valid  = 1'b0;
        i_sample = 0;
        @(posedge clk);
        #1;
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", o_valid); end
        checks++; if (o_period !== 24'd0) begin errors++; $display("FAIL reset_period: got %0d want 0", o_period); end
        checks++; if (o_peak !== 0) begin errors++; $display("FAIL reset_peak: got %0d want 0", o_peak); end
        checks++; if (o_trough !== 0) begin errors++; $display("FAIL reset_trough: got %0d want 0", o_trough); end
        checks++; if (o_ampl !== 0) begin errors++; $display("FAIL reset_ampl: got %0d want 0", o_ampl); end
        checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b want 0", o_locked); end
        checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %0b want 0", o_timeout); end
    endtask

    task automatic test_period_lock();
        int   nv;
        logic exp_v;
        logic exp_lk;
        do_reset();
        nv = 0;
        for (int k = 0; k < 240; k++) begin
            send(tri_val(k, 20), 1'b1);
            exp_v = (k >= 62) && ((k - 22) % 40 == 0);
            if (exp_v) nv++;
            checks++;
            if (o_valid !== exp_v) begin
                errors++; $display("FAIL p40_valid k=%0d: got %0b want %0b", k, o_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (o_period !== 24'd40 || o_peak !== 100 || o_trough !== -100 || o_ampl !== 200) begin
                    errors++;
                    $display("FAIL p40_meas k=%0d: got per=%0d pk=%0d tr=%0d amp=%0d want 40/100/-100/200",
                             k, o_period, o_peak, o_trough, o_ampl);
                end
            end
            checks++;
            if (o_locked !== (nv >= 5)) begin
                errors++; $display("FAIL p40_locked k=%0d: got %0b want %0b", k, o_locked, nv >= 5);
            end
        end
        for (int j = 0; j < 100; j++) begin
            send(tri_val(j, 30), 1'b1);
            exp_v  = (j == 33) || (j == 93);
            exp_lk = (j < 33);
            checks++;
            if (o_valid !== exp_v) begin
                errors++; $display("FAIL p60_valid j=%0d: got %0b want %0b", j, o_valid, exp_v);
            end
            checks++;
            if (o_locked !== exp_lk) begin
                errors++; $display("FAIL p60_locked j=%0d: got %0b want %0b", j, o_locked, exp_lk);
            end
            if (j == 33) begin
                checks++;
                if (o_period !== 24'd50) begin
                    errors++; $display("FAIL p50_period: got %0d want 50", o_period);
                end
            end
            if (j == 93) begin
                checks++;
                if (o_period !== 24'd60 || o_peak !== 100 || o_trough !== -100 || o_ampl !== 200) begin
                    errors++;
                    $display("FAIL p60_meas: got per=%0d pk=%0d tr=%0d amp=%0d want 60/100/-100/200",
                             o_period, o_peak, o_trough, o_ampl);
                end
            end
        end
    endtask

    task automatic test_valid_toggle();
        logic exp_v;
        int   c62;
        int   c102;
        do_reset();
        c62  = 0;
        c102 = 0;
        for (int k = 0; k < 120; k++) begin
            send(tri_val(k, 20), 1'b1);
            exp_v = (k == 62) || (k == 102);
            checks++;
            if (o_valid !== exp_v) begin
                errors++; $display("FAIL gap_valid k=%0d: got %0b want %0b", k, o_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (o_period !== 24'd40) begin
                    errors++; $display("FAIL gap_period k=%0d: got %0d want 40", k, o_period);
                end
            end
            if (k == 62) c62 = cyc;
            if (k == 102) c102 = cyc;
            send(12345, 1'b0);
            checks++;
            if (o_valid !== 1'b0) begin
                errors++; $display("FAIL gap_idle_valid k=%0d: got %0b want 0", k, o_valid);
            end
        end
        checks++;
        if (c102 - c62 !== 80) begin
            errors++; $display("FAIL gap_spacing: got %0d clocks want 80", c102 - c62);
        end
    endtask

    task automatic test_ripple();
        logic exp_v;
        do_reset();
        for (int k = 0; k < 120; k++) begin
            send(tri_val(k, 20) + (((k % 2) == 1) ? 7 : -7), 1'b1);
            exp_v = (k == 62) || (k == 102);
            checks++;
            if (o_valid !== exp_v) begin
                errors++; $display("FAIL ripple_valid k=%0d: got %0b want %0b", k, o_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (o_period !== 24'd40 || o_peak !== 97 || o_trough !== -107 || o_ampl !== 204) begin
                    errors++;
                    $display("FAIL ripple_meas k=%0d: got per=%0d pk=%0d tr=%0d amp=%0d want 40/97/-107/204",
                             k, o_period, o_peak, o_trough, o_ampl);
                end
            end
        end
    endtask

    task automatic test_timeout();
        logic exp_v;
        do_reset();
        for (int k = 0; k <= 22; k++) begin
            send(tri_val(k, 20), 1'b1);
            checks++;
            if (o_valid !== 1'b0) begin
                errors++; $display("FAIL to_first_valid k=%0d: got %0b want 0", k, o_valid);
            end
        end
        for (int j = 1; j <= 100; j++) begin
            send(50, 1'b1);
            checks++;
            if (o_timeout !== (j == 100)) begin
                errors++; $display("FAIL to_pulse j=%0d: got %0b want %0b", j, o_timeout, j == 100);
            end
        end
        checks++;
        if (o_locked !== 1'b0 || o_peak !== 100 || o_period !== 24'd0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL to_hold: got lk=%0b pk=%0d per=%0d v=%0b want 0/100/0/0",
                     o_locked, o_peak, o_period, o_valid);
        end
        send(0, 1'b0);
        checks++;
        if (o_timeout !== 1'b0) begin
            errors++; $display("FAIL to_drop: got %0b want 0", o_timeout);
        end
        for (int k = 0; k <= 62; k++) begin
            send(tri_val(k, 20), 1'b1);
            exp_v = (k == 62);
            checks++;
            if (o_valid !== exp_v) begin
                errors++; $display("FAIL to_restart_valid k=%0d: got %0b want %0b", k, o_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (o_period !== 24'd40) begin
                    errors++; $display("FAIL to_restart_period: got %0d want 40", o_period);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic exp_v;
        do_reset();
        for (int k = 0; k <= 110; k++) send(tri_val(k, 20), 1'b1);
        i_rst    = 1'b1;
        i_valid  = 1'b1;
        i_sample = tri_val(111, 20);
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_period !== 24'd0 || o_peak !== 0 || o_trough !== 0
            || o_ampl !== 0 || o_locked !== 1'b0 || o_timeout !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got v=%0b per=%0d pk=%0d tr=%0d amp=%0d lk=%0b to=%0b want all 0",
                     o_valid, o_period, o_peak, o_trough, o_ampl, o_locked, o_timeout);
        end
        for (int k = 0; k <= 62; k++) begin
            send(tri_val(k, 20), 1'b1);
            exp_v = (k == 62);
            checks++;
            if (o_valid !== exp_v) begin
                errors++; $display("FAIL mid_resume_valid k=%0d: got %0b want %0b", k, o_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (o_period !== 24'd40 || o_peak !== 100 || o_trough !== -100 || o_ampl !== 200) begin
                    errors++;
                    $display("FAIL mid_resume_meas: got per=%0d pk=%0d tr=%0d amp=%0d want 40/100/-100/200",
                             o_period, o_peak, o_trough, o_ampl);
                end
            end
        end
    endtask

    task automatic test_constant();
        do_reset();
        for (int k = 0; k < 150; k++) begin
            send(50, 1'b1);
            checks++;
            if (o_valid !== 1'b0 || o_timeout !== 1'b0) begin
                errors++; $display("FAIL const k=%0d: got v=%0b to=%0b want 0/0", k, o_valid, o_timeout);
            end
        end
    endtask

    initial begin
        i_rst    = 1'b1;
        i_valid  = 1'b0;
        i_sample = 0;
        test_reset();
        test_period_lock();
        test_valid_toggle();
        test_ripple();
        test_timeout();
        test_reset_mid();
        test_constant();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
